aes_job_sequencer: RTL
======================

// Module: aes_job_sequencer
// PURPOSE
//  Upstream command sequencer for AESTop. Accepts one job (256-bit key, direction, block count), issues the
//  key-load command (opcode 0), then one encrypt (1) or decrypt (2) command per 128-bit block from the host
//  block stream, and returns each AESTop result on a registered result stream. One AES op outstanding at a time.
// PARAMETERS
//  CNT_W      16     width of job block count / internal block counter
//  TIMEOUT    4096   max cycles waiting for aes_input_ready or aes_output_valid before abort (>=2)
// PORTS
//  clk              in   1    clock, all logic on posedge
//  rst              in   1    synchronous, active-high reset
//  job_valid        in   1    job descriptor valid
//  job_ready        out  1    high only in IDLE
//  job_key          in   256  AES-256 key, sampled on job handshake
//  job_decrypt      in   1    0 = encrypt (opcode 1), 1 = decrypt (opcode 2), sampled on job handshake
//  job_nblocks      in   CNT_W number of blocks in job, sampled on job handshake (0 allowed)
//  blk_valid        in   1    host block valid
//  blk_ready        out  1    high only in FETCH
//  blk_data         in   128  host block
//  aes_input_valid  out  1    to AESTop.input_valid
//  aes_input_ready  in   1    from AESTop.input_ready
//  aes_opcode       out  7    to AESTop.opcode
//  aes_data_in      out  256  to AESTop.data_in: key, or {block,128'd0}
//  aes_output_valid in   1    from AESTop.output_valid
//  aes_output_ready out  1    to AESTop.output_ready
//  aes_data_out     in   128  from AESTop.data_out
//  res_valid        out  1    result valid
//  res_ready        in   1    result consumer ready
//  res_data         out  128  registered result block
//  res_last         out  1    high with final block of job
//  job_done         out  1    one-cycle pulse at job end (normal or abort)
//  job_err          out  1    sticky timeout flag; cleared on next job handshake
// BEHAVIOUR
//  Handshake: transfer iff valid&&ready on a posedge. Valid outputs and their data held stable until transfer.
//  Reset: state=IDLE, counters 0; job_ready=1, all other outputs 0 (aes_opcode=0, aes_data_in=0, job_err=0).
//  States:
//   IDLE   job_ready=1. On job handshake latch key/dir/nblocks, clear job_err, cnt=0 -> KEY.
//   KEY    aes_input_valid=1, opcode=0, data_in=key. On aes handshake -> KACK.
//   KACK   aes_output_ready=1; aes_output_valid discards data_out (key ack). If nblocks==0 -> DONE else -> FETCH.
//   FETCH  blk_ready=1. On blk handshake latch block -> ISSUE. No timeout (host-paced).
//   ISSUE  aes_input_valid=1, opcode=1/2, data_in={block,128'd0}. On handshake -> WAIT.
//   WAIT   aes_output_ready=1. On aes_output_valid: res_data<=data_out, res_last<=(cnt==nblocks-1),
//          cnt<=cnt+1 -> RES.
//   RES    res_valid=1. On res handshake: if res_last -> DONE else -> FETCH.
//   DONE   job_done=1 for one cycle -> IDLE.
//  Latency: job handshake to first aes_input_valid = 1 cycle; aes_output_valid to res_valid = 1 cycle;
//   res handshake of last block to job_done = 1 cycle.
//  Timeout: counter cleared on every state entry, counts in KEY, KACK, ISSUE, WAIT; at TIMEOUT-1 sets
//   job_err=1 -> DONE (no res for the pending block). Remaining host blocks are not consumed.
//  aes_output_valid outside KACK/WAIT: ignored (aes_output_ready=0). Host back-pressure on res stalls
//   AESTop (no new command until result drained). cnt compare is unsigned CNT_W; nblocks=2^CNT_W-1 legal.
//  Reset mid-operation: abandons job immediately, no job_done pulse; AESTop reset by same rst.
// TESTING (bench with AESTop or behavioural model)
//  Reset, idle 5 cycles -> job_ready=1, every other output 0, no AES traffic.
//  Key 000102..1f, encrypt, 1 block 00112233445566778899aabbccddeeff -> opcode 0 then 1;
//   res_data=8ea2b7ca516745bfeafc49904b496089, res_last=1, job_done pulse, job_err=0.
//  Decrypt job same key, block 8ea2b7ca...6089 -> res_data=00112233445566778899aabbccddeeff.
//  nblocks=3, res_ready low 10 cycles per block -> no 2nd opcode-1 issue before 1st result taken;
//   res_last only on 3rd; exactly 3 blk handshakes.
//  nblocks=0 -> one key load, zero blk handshakes, job_done 1 cycle after key ack.
//  Model never asserts aes_output_valid in WAIT -> job_err=1 and job_done after TIMEOUT cycles; next
//   job clears job_err; rst asserted in ISSUE -> IDLE next cycle, no job_done.

Source files
------------

// File: rtl/aes_job_sequencer.sv
// Upstream command sequencer for AESTop: loads a 256-bit key, then issues one
// encrypt/decrypt command per host block and returns each result on a
// registered result stream. Only one AES operation is ever outstanding.
module aes_job_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [255:0]     job_key,
  input  logic             job_decrypt,
  input  logic [CNT_W-1:0] job_nblocks,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [127:0]     blk_data,
  output logic             aes_input_valid,
  input  logic             aes_input_ready,
  output logic [6:0]       aes_opcode,
  output logic [255:0]     aes_data_in,
  input  logic             aes_output_valid,
  output logic             aes_output_ready,
  input  logic [127:0]     aes_data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [127:0]     res_data,
  output logic             res_last,
  output logic             job_done,
  output logic             job_err
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_KACK, S_FETCH, S_ISSUE, S_WAIT, S_RES, S_DONE
  } state_t;

  state_t           state, state_next;
  logic [255:0]     key_q;
  logic             decrypt_q;
  logic [CNT_W-1:0] nblocks_q;
  logic [CNT_W-1:0] cnt_q;
  logic [127:0]     block_q;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;
  logic             timed_out;

  assign tmo_hit = (tmo_q == TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and Moore outputs; the AES wait states abort on timeout.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_next       = state;
    timed_out        = 1'b0;
    job_ready        = 1'b0;
    blk_ready        = 1'b0;
    aes_input_valid  = 1'b0;
    aes_opcode       = 7'd0;
    aes_data_in      = '0;
    aes_output_ready = 1'b0;
    res_valid        = 1'b0;
    job_done         = 1'b0;
    unique case (state)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_next = S_KEY;
      end
      S_KEY: begin
        aes_input_valid = 1'b1;
        aes_data_in     = key_q;
        if (aes_input_ready) state_next = S_KACK;
        else if (tmo_hit) begin
          state_next = S_DONE;
          timed_out  = 1'b1;
        end
      end
      S_KACK: begin
        aes_output_ready = 1'b1;
        if (aes_output_valid) state_next = (nblocks_q == '0) ? S_DONE : S_FETCH;
        else if (tmo_hit) begin
          state_next = S_DONE;
          timed_out  = 1'b1;
        end
      end
      S_FETCH: begin
        blk_ready = 1'b1;
        if (blk_valid) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        aes_input_valid = 1'b1;
        aes_opcode      = decrypt_q ? 7'd2 : 7'd1;
        aes_data_in     = {block_q, 128'd0};
        if (aes_input_ready) state_next = S_WAIT;
        else if (tmo_hit) begin
          state_next = S_DONE;
          timed_out  = 1'b1;
        end
      end
      S_WAIT: begin
        aes_output_ready = 1'b1;
        if (aes_output_valid) state_next = S_RES;
        else if (tmo_hit) begin
          state_next = S_DONE;
          timed_out  = 1'b1;
        end
      end
      S_RES: begin
        res_valid = 1'b1;
        if (res_ready) state_next = res_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        job_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Job context, block/result capture, block counter, timeout counter, error flag.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well so res_data/res_last read as
    // defined zeros out of reset rather than X.
    if (rst) begin
      key_q     <= '0;
      decrypt_q <= 1'b0;
      nblocks_q <= '0;
      cnt_q     <= '0;
      block_q   <= '0;
      tmo_q     <= '0;
      res_data  <= '0;
      res_last  <= 1'b0;
      job_err   <= 1'b0;
    end else begin
      // Restart the timeout window on every state change.
      if (state_next != state)
        tmo_q <= '0;
      else if (state inside {S_KEY, S_KACK, S_ISSUE, S_WAIT})
        tmo_q <= tmo_q + TMO_ONE;

      if (state == S_IDLE && job_valid) begin
        key_q     <= job_key;
        decrypt_q <= job_decrypt;
        nblocks_q <= job_nblocks;
        cnt_q     <= '0;
        job_err   <= 1'b0;
      end

      if (state == S_FETCH && blk_valid) block_q <= blk_data;

      if (state == S_WAIT && aes_output_valid) begin
        res_data <= aes_data_out;
        res_last <= (cnt_q == nblocks_q - CNT_ONE);
        cnt_q    <= cnt_q + CNT_ONE;
      end

      if (timed_out) job_err <= 1'b1;
    end
  end

endmodule
